// File: rtl/llc_cache_pkg.sv
// Shared types, widths and line helpers for the direct-mapped last-level cache.
package llc_cache_pkg;

  localparam int OFFSET_W = 5;
  localparam int LINE_W   = 256;
  localparam int WORD_W   = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  // Extract 32-bit word w (0..7) from a cache line.
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [2:0] w);
    return line[32'(w)*WORD_W +: WORD_W];
  endfunction

  // Replace the enabled bytes of word w in a line with the matching bytes of wd.
  function automatic logic [LINE_W-1:0] merge_line(input logic [LINE_W-1:0] line,
                                                   input logic [2:0] w,
                                                   input logic [WORD_W-1:0] wd,
                                                   input logic [3:0] m);
    logic [LINE_W-1:0] r;
    r = line;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) r[32'(w)*WORD_W + b*8 +: 8] = wd[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/llc_cache_array.sv
// Storage for the cache: data, tag, valid and dirty arrays.
// One combinational read port and one write port per array; only valid/dirty reset.
module llc_cache_array
  import llc_cache_pkg::*;
#(
  parameter int NUM_SETS = 8,
  parameter int IDX_W    = $clog2(NUM_SETS),
  parameter int TAG_W    = 32 - OFFSET_W - IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [LINE_W-1:0] o_rd_data,
  output logic [TAG_W-1:0]  o_rd_tag,
  output logic              o_rd_valid,
  output logic              o_rd_dirty,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic              i_data_we,
  input  logic [LINE_W-1:0] i_wr_data,
  input  logic              i_tag_we,
  input  logic [TAG_W-1:0]  i_wr_tag,
  input  logic              i_valid_we,
  input  logic              i_wr_valid,
  input  logic              i_dirty_we,
  input  logic              i_wr_dirty
);

  logic [LINE_W-1:0]   r_data [NUM_SETS];
  logic [TAG_W-1:0]    r_tag  [NUM_SETS];
  logic [NUM_SETS-1:0] r_valid;
  logic [NUM_SETS-1:0] r_dirty;

  // Data and tag arrays: written without reset, contents meaningless until valid.
  always_ff @(posedge clk) begin
    if (i_data_we) r_data[i_wr_idx] <= i_wr_data;
    if (i_tag_we)  r_tag[i_wr_idx]  <= i_wr_tag;
  end

  // Valid/dirty bits: cleared on reset so every set starts empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (i_valid_we) r_valid[i_wr_idx] <= i_wr_valid;
      if (i_dirty_we) r_dirty[i_wr_idx] <= i_wr_dirty;
    end
  end

  assign o_rd_data  = r_data[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_dirty = r_dirty[i_rd_idx];

endmodule

// File: rtl/llc_cache.sv
// Direct-mapped write-back cache: FSM, lookup and array write control.
// Hit/miss is precomputed on the cycle entering COMPARE so all outputs are registered.
module llc_cache
  import llc_cache_pkg::*;
#(
  parameter int NUM_SETS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cpu_addr,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [3:0]        cpu_wmask,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_resp,
  output logic [LINE_W-1:0] ca_line_o,
  input  logic [LINE_W-1:0] ca_line_i,
  output logic [31:0]       ca_address,
  output logic              ca_read,
  output logic              ca_write,
  input  logic              ca_resp
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 32 - OFFSET_W - IDX_W;

  state_t            r_state;
  logic              r_cpu_resp;
  logic [31:0]       r_cpu_rdata;
  logic [LINE_W-1:0] r_ca_line_o;
  logic [31:0]       r_ca_address;
  logic              r_ca_read;
  logic              r_ca_write;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [2:0]        w_word;
  logic [31:0]       w_line_addr;
  logic [LINE_W-1:0] w_rd_data;
  logic [TAG_W-1:0]  w_rd_tag;
  logic              w_rd_valid;
  logic              w_rd_dirty;
  logic              w_hit;
  logic              w_req;
  logic              w_wr_only;
  logic              w_unused_addr;

  logic              w_data_we;
  logic [LINE_W-1:0] w_wr_data;
  logic              w_tag_we;
  logic              w_valid_we;
  logic              w_wr_valid;
  logic              w_dirty_we;
  logic              w_wr_dirty;

  assign w_idx         = cpu_addr[OFFSET_W +: IDX_W];
  assign w_tag         = cpu_addr[31 -: TAG_W];
  assign w_word        = cpu_addr[4:2];
  assign w_line_addr   = {w_tag, w_idx, {OFFSET_W{1'b0}}};
  assign w_hit         = w_rd_valid && (w_rd_tag == w_tag);
  assign w_req         = cpu_read | cpu_write;
  assign w_wr_only     = cpu_write && !cpu_read;
  assign w_unused_addr = ^cpu_addr[1:0];

  llc_cache_array #(
    .NUM_SETS (NUM_SETS)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .i_rd_idx   (w_idx),
    .o_rd_data  (w_rd_data),
    .o_rd_tag   (w_rd_tag),
    .o_rd_valid (w_rd_valid),
    .o_rd_dirty (w_rd_dirty),
    .i_wr_idx   (w_idx),
    .i_data_we  (w_data_we),
    .i_wr_data  (w_wr_data),
    .i_tag_we   (w_tag_we),
    .i_wr_tag   (w_tag),
    .i_valid_we (w_valid_we),
    .i_wr_valid (w_wr_valid),
    .i_dirty_we (w_dirty_we),
    .i_wr_dirty (w_wr_dirty)
  );

  // Array write control: write-hit merge, writeback dirty clear, and line fill.
  always_comb begin
    w_data_we  = 1'b0;
    w_wr_data  = ca_line_i;
    w_tag_we   = 1'b0;
    w_valid_we = 1'b0;
    w_wr_valid = 1'b0;
    w_dirty_we = 1'b0;
    w_wr_dirty = 1'b0;
    if (!rst) begin
      case (r_state)
        COMPARE: begin
          if (r_cpu_resp && w_wr_only && (cpu_wmask != 4'b0000)) begin
            w_data_we  = 1'b1;
            w_wr_data  = merge_line(w_rd_data, w_word, cpu_wdata, cpu_wmask);
            w_dirty_we = 1'b1;
            w_wr_dirty = 1'b1;
          end
        end
        WRITEBACK: begin
          if (ca_resp) begin
            w_dirty_we = 1'b1;
            w_wr_dirty = 1'b0;
          end
        end
        ALLOCATE: begin
          if (ca_resp) begin
            w_data_we  = 1'b1;
            w_wr_data  = ca_line_i;
            w_tag_we   = 1'b1;
            w_valid_we = 1'b1;
            w_wr_valid = 1'b1;
            w_dirty_we = 1'b1;
            w_wr_dirty = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Controller FSM with registered CPU and adaptor outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cpu_resp   <= 1'b0;
      r_cpu_rdata  <= '0;
      r_ca_line_o  <= '0;
      r_ca_address <= '0;
      r_ca_read    <= 1'b0;
      r_ca_write   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_state     <= COMPARE;
            r_cpu_resp  <= w_hit;
            r_cpu_rdata <= (w_hit && cpu_read) ? line_word(w_rd_data, w_word) : '0;
          end
        end
        COMPARE: begin
          if (r_cpu_resp) begin
            r_state     <= IDLE;
            r_cpu_resp  <= 1'b0;
            r_cpu_rdata <= '0;
          end else if (w_rd_valid && w_rd_dirty) begin
            r_state      <= WRITEBACK;
            r_ca_write   <= 1'b1;
            r_ca_address <= {w_rd_tag, w_idx, {OFFSET_W{1'b0}}};
            r_ca_line_o  <= w_rd_data;
          end else begin
            r_state      <= ALLOCATE;
            r_ca_read    <= 1'b1;
            r_ca_address <= w_line_addr;
          end
        end
        WRITEBACK: begin
          if (ca_resp) begin
            r_state      <= ALLOCATE;
            r_ca_write   <= 1'b0;
            r_ca_line_o  <= '0;
            r_ca_read    <= 1'b1;
            r_ca_address <= w_line_addr;
          end
        end
        ALLOCATE: begin
          if (ca_resp) begin
            r_state      <= COMPARE;
            r_ca_read    <= 1'b0;
            r_ca_address <= '0;
            r_cpu_resp   <= 1'b1;
            r_cpu_rdata  <= cpu_read ? line_word(ca_line_i, w_word) : '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cpu_resp   = r_cpu_resp;
  assign cpu_rdata  = r_cpu_rdata;
  assign ca_line_o  = r_ca_line_o;
  assign ca_address = r_ca_address;
  assign ca_read    = r_ca_read;
  assign ca_write   = r_ca_write;

endmodule

// File: doc/llc_cache.md
LLC_CACHE -- requirements
Module: llc_cache

Interface
REQ-001 SHALL have parameter NUM_SETS, default 8, number of direct-mapped sets (power of 2, 2..64).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port cpu_addr, input, 32, byte address; bits [1:0] ignored.
REQ-005 SHALL have port cpu_read, input, 1, read request; held until cpu_resp.
REQ-006 SHALL have port cpu_write, input, 1, write request; held until cpu_resp.
REQ-007 SHALL have port cpu_wmask, input, 4, byte enables for cpu_wdata.
REQ-008 SHALL have port cpu_wdata, input, 32, write word.
REQ-009 SHALL have port cpu_rdata, output, 32, read word; valid only while cpu_resp=1.
REQ-010 SHALL have port cpu_resp, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port ca_line_o, output, 256, victim line to the cacheline adaptor.
REQ-012 SHALL have port ca_line_i, input, 256, fill line from the cacheline adaptor.
REQ-013 SHALL have port ca_address, output, 32, line-aligned address (bits [4:0]=0).
REQ-014 SHALL have ports ca_read, output, 1, and ca_write, output, 1, line requests, never both high.
REQ-015 SHALL have port ca_resp, input, 1, adaptor completion pulse.

Function
REQ-016 SHALL decode cpu_addr as offset [4:0], index [4+log2(NUM_SETS):5], tag = remaining upper bits.
REQ-017 SHALL implement FSM states IDLE, COMPARE, WRITEBACK, ALLOCATE.
REQ-018 SHALL transition IDLE->COMPARE on (cpu_read|cpu_write); otherwise stay in IDLE.
REQ-019 SHALL, in COMPARE on hit (valid && tag match), pulse cpu_resp, return to IDLE; hit latency = request cycle N, resp in cycle N+1.
REQ-020 SHALL drive cpu_rdata = line word cpu_addr[4:2] on read hit.
REQ-021 SHALL, on write hit, merge cpu_wdata bytes per cpu_wmask into word cpu_addr[4:2] and set dirty only if cpu_wmask != 0.
REQ-022 SHALL treat cpu_read and cpu_write both high as a read; no write performed.
REQ-023 SHALL, in COMPARE on miss, go WRITEBACK if victim valid&&dirty, else ALLOCATE.
REQ-024 SHALL, in WRITEBACK, hold ca_write=1, ca_address={victim tag,index,5'b0}, ca_line_o=victim data until ca_resp, then clear dirty and go ALLOCATE.
REQ-025 SHALL, in ALLOCATE, hold ca_read=1, ca_address={cpu tag,index,5'b0} until ca_resp; on ca_resp write ca_line_i, tag, valid=1, dirty=0, go COMPARE.
REQ-026 SHALL drop ca_read/ca_write the cycle after ca_resp is sampled.
REQ-027 SHALL ignore ca_resp outside WRITEBACK/ALLOCATE.
REQ-028 SHALL hold cpu_resp=0 in all states other than COMPARE-hit.
REQ-029 SHALL not change any tag/valid/dirty/data state for a set other than the addressed index.

Reset
REQ-030 SHALL, on rst, enter IDLE and clear all valid and dirty bits; data/tag arrays not reset.
REQ-031 SHALL drive cpu_resp, ca_read, ca_write = 0, and cpu_rdata, ca_line_o, ca_address = 0 in the reset cycle and in IDLE.
REQ-032 SHALL, on rst mid WRITEBACK/ALLOCATE, abandon the transfer, drop ca_read/ca_write next cycle, leave the target set invalid.

Structure
REQ-033 SHALL place state enum, OFFSET_W=5, LINE_W=256, WORD_W=32 in package llc_cache_pkg.
REQ-034 SHALL contain one sub-module llc_cache_array holding data, tag, valid, dirty with one read and one write port per array.
REQ-035 SHALL keep FSM and datapath muxing in llc_cache; target 200-350 RTL lines total.

Verification
REQ-036 Reset, read 0x0000_0040, adaptor returns line with word0=0xDEAD_BEEF -> ca_read with ca_address=0x0000_0040, then cpu_resp, cpu_rdata=0xDEAD_BEEF.
REQ-037 Repeat read 0x0000_0040 -> cpu_resp in cycle N+1, ca_read never asserted.
REQ-038 Write 0x0000_0044 wdata=0x1122_3344 wmask=4'b0011 over word 0xAAAA_AAAA -> read back 0xAAAA_3344, set dirty.
REQ-039 Then read 0x0001_0040 (same index, new tag) -> ca_write at 0x0000_0040 with modified line, then ca_read at 0x0001_0040, then cpu_resp.
REQ-040 Assert rst during ALLOCATE with ca_resp withheld -> ca_read=0 next cycle, next read of that address misses again.
REQ-041 Write with cpu_wmask=0 to clean resident line, then evict -> no ca_write, direct ca_read.
